// File: rtl/fpga_srl_mem_if.sv
// ----------------------------------------------------------------------------
// fpga_srl_mem_if
//   Bus bundle for the addressable shift-register store fpga_srl_mem.
//   Optional macro: FPGA_SRL_DOUT_REG_EN adds the registered tap output dout_q.
//
//   Signals
//     din       DWIDTH  word shifted into stage 0 on a write
//     we        1       shift enable, sampled on the rising clock edge
//     addr      AWIDTH  tap select, 0 = newest word, 2**AWIDTH-1 = oldest stage
//     dout_comb DWIDTH  combinational read of stage[addr]
//     dout_q    DWIDTH  registered copy of dout_comb (FPGA_SRL_DOUT_REG_EN only)
//
//   Modports
//     master : the user of the store (FIFO controller, testbench)
//     slave  : the store itself
// ----------------------------------------------------------------------------
interface fpga_srl_mem_if #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 4
);
  logic [DWIDTH-1:0] din;
  logic              we;
  logic [AWIDTH-1:0] addr;
  logic [DWIDTH-1:0] dout_comb;
`ifdef FPGA_SRL_DOUT_REG_EN
  logic [DWIDTH-1:0] dout_q;
`endif

  modport master (
    output din,
    output we,
    output addr,
`ifdef FPGA_SRL_DOUT_REG_EN
    input  dout_q,
`endif
    input  dout_comb
  );

  modport slave (
    input  din,
    input  we,
    input  addr,
`ifdef FPGA_SRL_DOUT_REG_EN
    output dout_q,
`endif
    output dout_comb
  );
endinterface

// File: rtl/fpga_srl_mem.sv
// ----------------------------------------------------------------------------
// fpga_srl_mem
//   Addressable shift-register storage: 2**AWIDTH stages of DWIDTH bits with a
//   combinational tap read at a selectable depth. Used as the storage element
//   of shallow synchronous FIFOs, where addr carries the occupancy-1 pointer
//   and dout_comb is the look-ahead output.
//   Optional macro: FPGA_SRL_DOUT_REG_EN adds a registered tap output dout_q.
//
//   Ports
//     clk     input   single clock, all state changes on its rising edge
//     arst_n  input   asynchronous active-low reset, clears every stage
//     bus     slave   din / we / addr in, dout_comb (and dout_q) out
// ----------------------------------------------------------------------------
module fpga_srl_mem #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 4
) (
  input  logic           clk,
  input  logic           arst_n,
  fpga_srl_mem_if.slave  bus
);
  localparam int DEPTH = 2 ** AWIDTH;

  logic [DWIDTH-1:0] stage_reg  [DEPTH];
  logic [DWIDTH-1:0] stage_next [DEPTH];

  // Shifted image of the chain: the new word enters at stage 0 and every
  // other stage takes its predecessor; the oldest word falls off the end.
  assign stage_next[0] = bus.din;
  generate
    for (genvar gi = 1; gi < DEPTH; gi++) begin : g_shift
      assign stage_next[gi] = stage_reg[gi-1];
    end
  endgenerate

  // No full/empty guard here: the caller owns overflow protection.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_reg[i] <= '0;
      end
    end else if (bus.we) begin
      stage_reg <= stage_next;
    end
  end

  // Every addr value selects a real stage, so there is no out-of-range case.
  assign bus.dout_comb = stage_reg[bus.addr];

`ifdef FPGA_SRL_DOUT_REG_EN
  logic [DWIDTH-1:0] dout_q_reg;

  // Samples the pre-edge tap, i.e. one cycle behind addr and contents.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      dout_q_reg <= '0;
    end else begin
      dout_q_reg <= stage_reg[bus.addr];
    end
  end

  assign bus.dout_q = dout_q_reg;
`endif

endmodule

// File: tb/tb_fpga_srl_mem.sv
// ----------------------------------------------------------------------------
// tb_fpga_srl_mem
//   Self-checking bench for fpga_srl_mem. A queue model (newest word at the
//   front, depth entries) predicts every tap; a negedge process compares the
//   DUT against it each cycle, and directed phases pin literal values.
//   Optional macro: FPGA_SRL_DOUT_REG_EN also checks dout_q.
// ----------------------------------------------------------------------------
module tb_fpga_srl_mem;
  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 2 ** AW;

  logic clk     = 1'b0;
  logic clk_run = 1'b1;
  logic arst_n;

  int n_checks = 0;
  int n_pass   = 0;

  fpga_srl_mem_if #(.DWIDTH(DW), .AWIDTH(AW)) bus ();

  fpga_srl_mem #(.DWIDTH(DW), .AWIDTH(AW)) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus)
  );

  // Clock can be frozen (high) so taps can be swept with no edge in between.
  always #5 if (clk_run) clk = ~clk;

  // ---------------- reference model ----------------
  logic [DW-1:0] model_q [$];
  logic [DW-1:0] exp_q = '0;

  task automatic model_clear();
    model_q.delete();
    for (int i = 0; i < DEPTH; i++) model_q.push_back('0);
    exp_q = '0;
  endtask

  initial model_clear();

  always @(negedge arst_n) model_clear();

  always @(posedge clk) begin
    if (!arst_n) begin
      model_clear();
    end else begin
      exp_q = model_q[bus.addr];
      if (bus.we) begin
        model_q.push_front(bus.din);
        void'(model_q.pop_back());
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (addr=%0d t=%0t)", name, act, exp, bus.addr, $time);
  endtask

  always @(negedge clk) begin
    chk("tap_vs_model", bus.dout_comb, model_q[bus.addr]);
`ifdef FPGA_SRL_DOUT_REG_EN
    chk("dout_q_vs_model", bus.dout_q, exp_q);
`endif
  end

  // ---------------- stimulus helpers ----------------
  task automatic wr(input logic w, input logic [DW-1:0] d, input logic [AW-1:0] a);
    bus.we   = w;
    bus.din  = d;
    bus.addr = a;
    @(posedge clk);
    #1;
    if (w) $display("write din=%h addr=%0d t=%0t", d, a, $time);
  endtask

  task automatic sweep_expect_zero(input string name);
    for (int a = 0; a < DEPTH; a++) begin
      bus.addr = a[AW-1:0];
      #1;
      chk(name, bus.dout_comb, '0);
    end
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    logic [DW-1:0] d;
    arst_n   = 1'b0;
    bus.we   = 1'b0;
    bus.din  = '0;
    bus.addr = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_addr0", bus.dout_comb, 16'h0000);
    bus.addr = 4'd15;
    #1;
    chk("reset_addr15", bus.dout_comb, 16'h0000);
    arst_n = 1'b1;

    // Async reset with no clock edge.
    repeat (DEPTH) wr(1'b1, 16'hAAAA, 4'd0);
    clk_run = 1'b0;
    bus.addr = 4'd5;
    #1;
    chk("pre_reset_aaaa", bus.dout_comb, 16'hAAAA);
    arst_n = 1'b0;
    #1;
    sweep_expect_zero("async_reset_tap");
`ifdef FPGA_SRL_DOUT_REG_EN
    chk("async_reset_dout_q", bus.dout_q, 16'h0000);
`endif
    arst_n = 1'b1;
    #1;
    clk_run = 1'b1;

    // Fill 1..16.
    for (int k = 1; k <= DEPTH; k++) wr(1'b1, k[DW-1:0], 4'd0);
    clk_run = 1'b0;
    bus.addr = 4'd0;  #1; chk("fill_addr0", bus.dout_comb, 16'h0010);
    bus.addr = 4'd15; #1; chk("fill_addr15", bus.dout_comb, 16'h0001);
    bus.addr = 4'd7;  #1; chk("fill_addr7", bus.dout_comb, 16'h0009);
    chk("model_pin_addr7", model_q[7], 16'h0009);
    clk_run = 1'b1;

    // Hold with din toggling.
    d = 16'h5555;
    for (int k = 0; k < 5; k++) begin
      wr(1'b0, d, 4'd0);
      d = ~d;
    end
    clk_run = 1'b0;
    for (int a = 0; a < DEPTH; a++) begin
      bus.addr = a[AW-1:0];
      #1;
      chk("hold_sweep", bus.dout_comb, 16'(DEPTH - a));
    end
    clk_run = 1'b1;

    // Overflow discards the oldest word.
    wr(1'b1, 16'h0011, 4'd0);
    clk_run = 1'b0;
    bus.addr = 4'd15; #1; chk("ovf_addr15", bus.dout_comb, 16'h0002);
    bus.addr = 4'd0;  #1; chk("ovf_addr0", bus.dout_comb, 16'h0011);
    chk("model_pin_ovf", model_q[15], 16'h0002);
    clk_run = 1'b1;

    // FIFO usage: addr tracks count-1, the oldest word stays visible.
    wr(1'b1, 16'h1234, 4'd0); chk("fifo_w1", bus.dout_comb, 16'h1234);
    wr(1'b1, 16'h5678, 4'd1); chk("fifo_w2", bus.dout_comb, 16'h1234);
    wr(1'b1, 16'h9ABC, 4'd2); chk("fifo_w3", bus.dout_comb, 16'h1234);
    clk_run = 1'b0;
    bus.we = 1'b0;
    bus.addr = 4'd1; #1; chk("fifo_addr1", bus.dout_comb, 16'h5678);
    bus.addr = 4'd0; #1; chk("fifo_addr0", bus.dout_comb, 16'h9ABC);
    clk_run = 1'b1;

    // Mid-operation reset between edges.
    wr(1'b1, 16'h0101, 4'd3);
    wr(1'b1, 16'h0202, 4'd3);
    arst_n = 1'b0;
    clk_run = 1'b0;
    #1;
    sweep_expect_zero("mid_reset_tap");
`ifdef FPGA_SRL_DOUT_REG_EN
    chk("mid_reset_dout_q", bus.dout_q, 16'h0000);
`endif
    arst_n = 1'b1;
    #1;
    clk_run = 1'b1;
    wr(1'b1, 16'hBEEF, 4'd0);
    clk_run = 1'b0;
    chk("beef_addr0", bus.dout_comb, 16'hBEEF);
`ifdef FPGA_SRL_DOUT_REG_EN
    chk("beef_dout_q_lag", bus.dout_q, 16'h0000);
`endif
    bus.addr = 4'd1; #1; chk("beef_addr1", bus.dout_comb, 16'h0000);
    clk_run = 1'b1;
    wr(1'b0, 16'h0000, 4'd0);
`ifdef FPGA_SRL_DOUT_REG_EN
    chk("beef_dout_q", bus.dout_q, 16'hBEEF);
`endif

    // Randomized traffic with occasional reset pulses between edges.
    for (int n = 0; n < 400; n++) begin
      wr(1'($urandom_range(0, 2) != 0), 16'($urandom), 4'($urandom));
      if ($urandom_range(0, 79) == 0) begin
        arst_n = 1'b0;
        #1;
        arst_n = 1'b1;
      end
    end
    bus.we = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/fpga_srl_mem.md
Name: fpga_srl_mem

Overview:
- Addressable shift-register storage: 2**AWIDTH stages of DWIDTH bits, with an asynchronous (combinational) tap-read at a selectable depth.
- Serves as the storage element of shallow synchronous FIFOs. There, the FIFO controller drives `addr` with its read pointer/occupancy, and `dout_comb` is the FIFO look-ahead output.
- Maps onto FPGA SRL primitives, or onto a plain register array.

Parameters:
- DWIDTH, 16, data word width in bits.
- AWIDTH, 4, tap address width; depth = 2**AWIDTH stages (16 by default).

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- arst_n  input  1  asynchronous active-low reset.
- din  input  DWIDTH  word shifted into stage 0 on a write.
- we  input  1  shift enable; when 1 at a rising clk edge, the chain shifts by one.
- addr  input  AWIDTH  tap select; 0 = newest word, 2**AWIDTH-1 = oldest stage.
- dout_comb  output  DWIDTH  combinational read of stage[addr].
- dout_q  output  DWIDTH  registered tap output; present only with FPGA_SRL_DOUT_REG_EN.

Behaviour:
- Storage: stage[0 .. 2**AWIDTH-1], each DWIDTH bits.
- Write, rising clk with we=1:
  - stage[0] <= din
  - stage[i] <= stage[i-1] for i = 1 .. 2**AWIDTH-1
  - the old stage[2**AWIDTH-1] is discarded.
- we=0: all stages hold.
- No internal full/empty protection. The shift happens unconditionally when we=1; overflow protection is the caller's job.
- Read: dout_comb = stage[addr], purely combinational, zero latency.
  - It follows addr changes within the same cycle.
  - After a write edge it reflects the shifted contents immediately, before the next edge.
- Every addr value is valid (full 2**AWIDTH range); there is no out-of-range case.
- After k writes (k ≤ depth), addr = k-1 returns the first word written. This is the FIFO usage: the occupancy-1 tap is the oldest word.
- Reset, arst_n=0:
  - Asynchronous: all stages clear to 0 immediately, so dout_comb = 0 for every addr.
  - dout_q (if present) clears to 0.
  - Writes are ignored while reset is asserted.
  - Reset asserted mid-operation discards all contents.
- Reset release: the first rising edge with arst_n=1 and we=1 performs a normal shift.
- Simultaneous write and addr change in the same cycle:
  - Before the edge, dout_comb shows pre-shift stage[addr].
  - After the edge, it shows post-shift stage[addr].
- X/undefined din is stored as-is; no sanitisation.

Optional Feature:
- Macro FPGA_SRL_DOUT_REG_EN.
- Defined:
  - Adds output port dout_q.
  - dout_q <= dout_comb on every rising clk edge (one-cycle latency relative to addr and contents).
  - Reset value 0.
- Undefined:
  - dout_q port and its register are absent.
  - Only dout_comb exists.

Test Plan:
- Reset: write 0xAAAA into all 16 stages, assert arst_n=0 with no clk edge → dout_comb = 0x0000 for all addr 0..15 immediately.
- Fill: write 0x0001..0x0010 in order (16 writes) → addr=0 reads 0x0010, addr=15 reads 0x0001, addr=7 reads 0x0009.
- Hold: with we=0 over 5 edges and din toggling → all 16 taps unchanged; sweep addr 0..15 combinationally with no clock → correct values at zero latency.
- Overflow discard: after the fill, write 0x0011 → addr=15 reads 0x0002, addr=0 reads 0x0011; 0x0001 is gone.
- FIFO pattern: write 0x1234, 0x5678, 0x9ABC with addr tracking count-1 (0, 1, 2) → dout_comb = 0x1234 after each write; then addr=1 → 0x5678, addr=0 → 0x9ABC.
- Mid-operation reset: during a write burst, pulse arst_n low between edges → all taps read 0; the next we=1 edge with din=0xBEEF gives addr=0 reads 0xBEEF, addr=1 reads 0. With FPGA_SRL_DOUT_REG_EN, dout_q = 0 during reset and equals the previous cycle's dout_comb afterwards.
